// File: rtl/lava_round_sequencer.sv
// lava_round_sequencer: round-level scheduler for the lava hazard.
// Tracks round phase, drives wall freeze and speed boosts, and emits a
// one-clk round_clear on restart.
// Optional feature: define LAVA_PAUSE_EN to add the pause_btn port and the
// PAUSE phase (4). Without it, phase 4 is unreachable.
module lava_round_sequencer #(
  parameter int unsigned BOOST_STEP    = 10,
  parameter int unsigned MAX_BOOSTS    = 7,
  parameter int unsigned RESTART_TICKS = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_tick,
  input  logic        any_input_level,
  input  logic        hit_lava_wall,
  input  logic        goal_reached,
  input  logic        score_inc,
`ifdef LAVA_PAUSE_EN
  input  logic        pause_btn,
`endif
  output logic [2:0]  phase,
  output logic        freeze,
  output logic        speed_boost_pulse,
  output logic        round_clear,
  output logic [15:0] score,
  output logic [2:0]  boost_level
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_RUN   = 3'd1,
    PH_WIN   = 3'd2,
    PH_OVER  = 3'd3,
    PH_PAUSE = 3'd4
  } phase_t;

  localparam logic [7:0] STEP_L = 8'(BOOST_STEP);
  localparam logic [2:0] MAX_L  = 3'(MAX_BOOSTS);
  localparam logic [7:0] HOLD_L = 8'(RESTART_TICKS);

  phase_t     state, state_nxt;
  logic [7:0] step_cnt;
  logic [1:0] pend, pend_nxt;
  logic [7:0] hold_cnt;

  logic in_run, in_end, score_ok, step_done, boost_fire, restart, pause_edge;

  assign in_run   = (state == PH_RUN);
  assign in_end   = (state == PH_WIN) || (state == PH_OVER);
  assign score_ok = score_inc && in_run;
  // step completes on the increment that would make step_cnt equal BOOST_STEP
  assign step_done = score_ok && (step_cnt == STEP_L - 8'd1);

  // boost strobe is combinational from registered state so the wall
  // controller samples it on the same tick
  assign boost_fire = game_tick && in_run && (pend != 2'd0) && (boost_level < MAX_L);
  assign speed_boost_pulse = boost_fire;

  assign restart = game_tick && in_end && (hold_cnt == HOLD_L) && any_input_level;

  assign phase = state;

`ifdef LAVA_PAUSE_EN
  logic pause_q;

  // remember the tick-sampled pause button for edge detection
  always_ff @(posedge clk) begin
    if (rst) pause_q <= 1'b0;
    else if (game_tick) pause_q <= pause_btn;
  end

  assign pause_edge = game_tick && pause_btn && !pause_q;
`else
  assign pause_edge = 1'b0;
`endif

  // pending-boost bookkeeping: a step completing on a boost cycle nets out
  always_comb begin
    pend_nxt = pend;
    unique case ({step_done, boost_fire})
      2'b10:   pend_nxt = (pend == 2'd3) ? 2'd3 : pend + 2'd1;
      2'b01:   pend_nxt = pend - 2'd1;
      default: pend_nxt = pend;
    endcase
  end

  // phase transitions, evaluated only on tick cycles; collision beats goal
  always_comb begin
    state_nxt = state;
    if (game_tick) begin
      unique case (state)
        PH_IDLE:  if (any_input_level) state_nxt = PH_RUN;
        PH_RUN: begin
          if (hit_lava_wall)     state_nxt = PH_OVER;
          else if (goal_reached) state_nxt = PH_WIN;
          else if (pause_edge)   state_nxt = PH_PAUSE;
        end
        PH_PAUSE: if (pause_edge) state_nxt = PH_RUN;
        PH_WIN, PH_OVER: if (restart) state_nxt = PH_IDLE;
        default:  state_nxt = PH_IDLE;
      endcase
    end
  end

  // phase register with registered freeze and round_clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= PH_IDLE;
      freeze      <= 1'b0;
      round_clear <= 1'b0;
    end else begin
      state       <= state_nxt;
      freeze      <= (state_nxt == PH_WIN) || (state_nxt == PH_OVER) ||
                     (state_nxt == PH_PAUSE);
      round_clear <= restart;
    end
  end

  // score, step and boost counters; all cleared by a restart
  always_ff @(posedge clk) begin
    if (rst) begin
      score       <= 16'd0;
      step_cnt    <= 8'd0;
      pend        <= 2'd0;
      boost_level <= 3'd0;
    end else if (restart) begin
      score       <= 16'd0;
      step_cnt    <= 8'd0;
      pend        <= 2'd0;
      boost_level <= 3'd0;
    end else begin
      if (score_ok) begin
        if (score != 16'hFFFF) score <= score + 16'd1;
        step_cnt <= step_done ? 8'd0 : step_cnt + 8'd1;
      end
      pend <= pend_nxt;
      if (boost_fire) boost_level <= boost_level + 3'd1;
    end
  end

  // hold counter: ticks spent in WIN/OVER, saturating at the restart threshold
  always_ff @(posedge clk) begin
    if (rst || restart) hold_cnt <= 8'd0;
    else if (game_tick && in_end && (hold_cnt != HOLD_L)) hold_cnt <= hold_cnt + 8'd1;
  end

endmodule

// File: tb/tb_lava_round_sequencer.sv
// Directed bench for lava_round_sequencer (BOOST_STEP=10, MAX_BOOSTS=2,
// RESTART_TICKS=3). Pause checks only when LAVA_PAUSE_EN is defined.
module tb_lava_round_sequencer;
  logic clk = 1'b0;
  logic rst, game_tick, any_input_level, hit_lava_wall, goal_reached, score_inc;
  logic pause_btn;
  logic [2:0] phase, boost_level;
  logic freeze, speed_boost_pulse, round_clear;
  logic [15:0] score;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  lava_round_sequencer #(.BOOST_STEP(10), .MAX_BOOSTS(2), .RESTART_TICKS(3)) dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .any_input_level(any_input_level),
    .hit_lava_wall(hit_lava_wall), .goal_reached(goal_reached), .score_inc(score_inc),
`ifdef LAVA_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .phase(phase), .freeze(freeze), .speed_boost_pulse(speed_boost_pulse),
    .round_clear(round_clear), .score(score), .boost_level(boost_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one tick cycle; the boost strobe is sampled mid-cycle and counted
  task automatic tick();
    @(negedge clk);
    game_tick = 1'b1;
    #1;
    if (speed_boost_pulse) pulses++;
    @(negedge clk);
    game_tick = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      score_inc = 1'b1;
      @(negedge clk);
      score_inc = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; game_tick = 1'b0; any_input_level = 1'b0; hit_lava_wall = 1'b0;
    goal_reached = 1'b0; score_inc = 1'b0; pause_btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_clear", 32'(round_clear), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_boost", 32'(boost_level), 32'd0);

    // ignored score outside RUN, then start
    incs(3);
    chk("idle_score", 32'(score), 32'd0);
    any_input_level = 1'b1;
    pulses = 0;
    tick();
    any_input_level = 1'b0;
    chk("start_phase", 32'(phase), 32'd1);
    chk("start_freeze", 32'(freeze), 32'd0);
    chk("start_nopulse", 32'(pulses), 32'd0);

    // 25 increments -> 2 pending boosts, one per tick
    incs(25);
    chk("score25", 32'(score), 32'd25);
    chk("boost_pre", 32'(boost_level), 32'd0);
    pulses = 0;
    tick();
    chk("boost_t1", 32'(pulses), 32'd1);
    tick();
    chk("boost_t2", 32'(pulses), 32'd2);
    tick();
    chk("boost_t3", 32'(pulses), 32'd2);
    chk("boost_lvl2", 32'(boost_level), 32'd2);

    // collision flag without a tick is ignored
    @(negedge clk); hit_lava_wall = 1'b1;
    @(negedge clk); hit_lava_wall = 1'b0;
    chk("hit_notick", 32'(phase), 32'd1);

    // goal -> WIN, then restart after the hold expires
    goal_reached = 1'b1;
    tick();
    goal_reached = 1'b0;
    chk("win_phase", 32'(phase), 32'd2);
    chk("win_freeze", 32'(freeze), 32'd1);
    any_input_level = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_noclear", 32'(round_clear), 32'd0);
      chk("hold_phase", 32'(phase), 32'd2);
    end
    tick();
    any_input_level = 1'b0;
    chk("restart_clear", 32'(round_clear), 32'd1);
    chk("restart_phase", 32'(phase), 32'd0);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_boost", 32'(boost_level), 32'd0);
    chk("restart_freeze", 32'(freeze), 32'd0);
    @(negedge clk);
    chk("clear_once", 32'(round_clear), 32'd0);

    // round 2: cap at MAX_BOOSTS=2 despite 4 completed steps
    any_input_level = 1'b1;
    tick();
    any_input_level = 1'b0;
    chk("r2_phase", 32'(phase), 32'd1);
    incs(40);
    chk("score40", 32'(score), 32'd40);
    pulses = 0;
    repeat (5) tick();
    chk("cap_pulses", 32'(pulses), 32'd2);
    chk("cap_lvl", 32'(boost_level), 32'd2);
    incs(10);
    tick();
    chk("cap_after", 32'(pulses), 32'd2);

    // both flags on one tick: OVER wins
    hit_lava_wall = 1'b1; goal_reached = 1'b1;
    tick();
    hit_lava_wall = 1'b0; goal_reached = 1'b0;
    chk("prio_phase", 32'(phase), 32'd3);
    chk("prio_freeze", 32'(freeze), 32'd1);
    any_input_level = 1'b1;
    repeat (4) tick();
    chk("over_clear", 32'(round_clear), 32'd1);
    chk("over_idle", 32'(phase), 32'd0);

    // reset mid-round beats simultaneous events
    tick();
    any_input_level = 1'b0;
    chk("r3_phase", 32'(phase), 32'd1);
    incs(12);
    chk("score12", 32'(score), 32'd12);
    @(negedge clk);
    rst = 1'b1; game_tick = 1'b1; hit_lava_wall = 1'b1;
    @(negedge clk);
    rst = 1'b0; game_tick = 1'b0; hit_lava_wall = 1'b0;
    chk("mid_phase", 32'(phase), 32'd0);
    chk("mid_score", 32'(score), 32'd0);
    chk("mid_clear", 32'(round_clear), 32'd0);
    chk("mid_freeze", 32'(freeze), 32'd0);
    pulses = 0;
    any_input_level = 1'b1;
    tick();
    any_input_level = 1'b0;
    tick();
    chk("mid_nopend", 32'(pulses), 32'd0);

`ifdef LAVA_PAUSE_EN
    // already in RUN: pause, ignore collision, unpause
    pause_btn = 1'b1;
    tick();
    chk("pause_phase", 32'(phase), 32'd4);
    chk("pause_freeze", 32'(freeze), 32'd1);
    hit_lava_wall = 1'b1;
    tick();
    hit_lava_wall = 1'b0;
    chk("pause_hit", 32'(phase), 32'd4);
    incs(2);
    chk("pause_score", 32'(score), 32'd0);
    pause_btn = 1'b0;
    tick();
    chk("pause_hold", 32'(phase), 32'd4);
    pause_btn = 1'b1;
    tick();
    chk("unpause_phase", 32'(phase), 32'd1);
    chk("unpause_freeze", 32'(freeze), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
